// File: rtl/cmpminmax.sv
// Streaming per-frame min/max tracker with signed/unsigned strict less-than.
// Define CMPMINMAX_IDX_EN to track first-occurrence indices of min and max.
module cmpminmax #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             is_signed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic [CNTW-1:0]  out_min_idx,
  output logic [CNTW-1:0]  out_max_idx,
  output logic [CNTW-1:0]  out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] ONE = CNTW'(1);

  state_t state_q, state_d;
  logic   accept;
  logic   sat;
  logic   mode_q;
  logic   min_lt;
  logic   max_lt;

  // MSB decides when signs differ; otherwise magnitude decides
  function automatic logic lt(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sgn
  );
    if (sgn && (a[WIDTH-1] != b[WIDTH-1]))
      return a[WIDTH-1];
    return a < b;
  endfunction

  assign accept = in_valid & in_ready;
  assign sat    = &out_count;
  assign min_lt = lt(in_data, out_min, mode_q);
  assign max_lt = lt(out_max, in_data, mode_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept)
          state_d = in_last ? HOLD : ACC;
      end
      HOLD: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_min   <= '0;
      out_max   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      mode_q    <= 1'b0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        out_min   <= in_data;
        out_max   <= in_data;
        out_count <= '0;
        out_ovf   <= 1'b0;
        mode_q    <= is_signed;
      end else begin
        if (sat) out_ovf   <= 1'b1;
        else     out_count <= out_count + ONE;
        if (min_lt) out_min <= in_data;
        if (max_lt) out_max <= in_data;
      end
    end
  end

`ifdef CMPMINMAX_IDX_EN
  logic [CNTW-1:0] nxt_idx;

  assign nxt_idx = out_count + ONE;

  // Indices freeze once the count saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_min_idx <= '0;
      out_max_idx <= '0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        out_min_idx <= '0;
        out_max_idx <= '0;
      end else if (!sat) begin
        if (min_lt) out_min_idx <= nxt_idx;
        if (max_lt) out_max_idx <= nxt_idx;
      end
    end
  end
`else
  assign out_min_idx = '0;
  assign out_max_idx = '0;
`endif

endmodule

// File: tb/tb_cmpminmax.sv
// Bench for cmpminmax: two instances (CNTW=8 and CNTW=2) share one stream
// and are checked against a frame-level reference model.
module tb_cmpminmax;

  logic        clk;
  logic        rst_n;
  logic        is_signed;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_min, out_max;
  logic [7:0]  out_min_idx, out_max_idx, out_count;

  logic        in_ready2, out_valid2, out_ovf2;
  logic [15:0] out_min2, out_max2;
  logic [1:0]  out_min_idx2, out_max_idx2, out_count2;

  int tests;
  int fails;
  logic [15:0] fq[$];

  cmpminmax #(.WIDTH(16), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n), .is_signed(is_signed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_max(out_max),
    .out_min_idx(out_min_idx), .out_max_idx(out_max_idx),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  cmpminmax #(.WIDTH(16), .CNTW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .is_signed(is_signed),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
    .out_min(out_min2), .out_max(out_max2),
    .out_min_idx(out_min_idx2), .out_max_idx(out_max_idx2),
    .out_count(out_count2), .out_ovf(out_ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int key(input logic [15:0] x, input logic s);
    return s ? int'($signed(x)) : int'({16'h0, x});
  endfunction

  task automatic model(input int cntw, input logic sgn,
                       output logic [15:0] mn, output logic [15:0] mx,
                       output int mni, output int mxi,
                       output int cnt, output logic ovf);
    int n = fq.size();
    int lim = 1 << cntw;
    int p = (n < lim) ? n : lim;
    logic [15:0] pmn, pmx;
    mn = fq[0];
    mx = fq[0];
    foreach (fq[i]) begin
      if (key(fq[i], sgn) < key(mn, sgn)) mn = fq[i];
      if (key(fq[i], sgn) > key(mx, sgn)) mx = fq[i];
    end
    pmn = fq[0];
    pmx = fq[0];
    for (int i = 0; i < p; i++) begin
      if (key(fq[i], sgn) < key(pmn, sgn)) pmn = fq[i];
      if (key(fq[i], sgn) > key(pmx, sgn)) pmx = fq[i];
    end
    mni = -1;
    mxi = -1;
    for (int i = 0; i < p; i++) begin
      if (mni < 0 && fq[i] == pmn) mni = i;
      if (mxi < 0 && fq[i] == pmx) mxi = i;
    end
`ifndef CMPMINMAX_IDX_EN
    mni = 0;
    mxi = 0;
`endif
    cnt = p - 1;
    ovf = (n > lim);
  endtask

  task automatic check_out(input logic [15:0] mn, input logic [15:0] mx,
                           input int mni, input int mxi, input int cnt,
                           input logic ovf, input logic [15:0] mn2,
                           input logic [15:0] mx2, input int mni2,
                           input int mxi2, input int cnt2,
                           input logic ovf2);
    chk("valid",   32'(out_valid),    32'(1));
    chk("ready",   32'(in_ready),     32'(0));
    chk("min",     32'(out_min),      32'(mn));
    chk("max",     32'(out_max),      32'(mx));
    chk("min_idx", 32'(out_min_idx),  32'(mni));
    chk("max_idx", 32'(out_max_idx),  32'(mxi));
    chk("count",   32'(out_count),    32'(cnt));
    chk("ovf",     32'(out_ovf),      32'(ovf));
    chk("valid2",  32'(out_valid2),   32'(1));
    chk("min2",    32'(out_min2),     32'(mn2));
    chk("max2",    32'(out_max2),     32'(mx2));
    chk("min_idx2", 32'(out_min_idx2), 32'(mni2));
    chk("max_idx2", 32'(out_max_idx2), 32'(mxi2));
    chk("count2",  32'(out_count2),   32'(cnt2));
    chk("ovf2",    32'(out_ovf2),     32'(ovf2));
  endtask

  task automatic run_frame(input logic sgn, input int hold,
                           input logic bubbles);
    logic [15:0] mn, mx, mn2, mx2;
    int mni, mxi, cnt, mni2, mxi2, cnt2;
    logic ovf, ovf2;
    int n = fq.size();
    model(8, sgn, mn, mx, mni, mxi, cnt, ovf);
    model(2, sgn, mn2, mx2, mni2, mxi2, cnt2, ovf2);
    for (int i = 0; i < n; i++) begin
      chk("acc_ready", 32'(in_ready), 32'(1));
      in_valid  = 1'b1;
      in_data   = fq[i];
      in_last   = (i == n - 1);
      is_signed = (i == 0) ? sgn : 1'($urandom);
      out_ready = (i == n - 1) ? 1'b0 : 1'($urandom);
      @(posedge clk);
      #1;
      if (i < n - 1) begin
        chk("early_valid", 32'(out_valid), 32'(0));
        if (bubbles && ($urandom % 4 == 0)) begin
          in_valid = 1'b0;
          in_data  = 16'($urandom);
          @(posedge clk);
          #1;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_out(mn, mx, mni, mxi, cnt, ovf, mn2, mx2, mni2, mxi2, cnt2, ovf2);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      in_data  = 16'($urandom);
      @(posedge clk);
      #1;
      check_out(mn, mx, mni, mxi, cnt, ovf,
                mn2, mx2, mni2, mxi2, cnt2, ovf2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 32'(0));
    chk("post_ready", 32'(in_ready),  32'(1));
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    is_signed = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready),  32'(1));
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_min",   32'(out_min),   32'(0));
    chk("rst_max",   32'(out_max),   32'(0));
    chk("rst_count", 32'(out_count), 32'(0));
    chk("rst_ovf",   32'(out_ovf),   32'(0));
    chk("rst_midx",  32'(out_min_idx), 32'(0));
    chk("rst_xidx",  32'(out_max_idx), 32'(0));
    rst_n = 1'b1;

    // out_ready while idle has no effect
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_oready", 32'(out_valid), 32'(0));

    fq = '{16'h0002, 16'hFFFF, 16'h0001};
    run_frame(1'b0, 0, 1'b0);
    chk("u_min",   32'(out_min),   32'h0001);
    chk("u_max",   32'(out_max),   32'hFFFF);
    chk("u_count", 32'(out_count), 32'd2);

    run_frame(1'b1, 1, 1'b0);
    chk("s_min", 32'(out_min), 32'hFFFF);
    chk("s_max", 32'(out_max), 32'h0002);

    fq = '{16'hFFFE, 16'hFFFF, 16'hFFFE, 16'hFFFF};
    run_frame(1'b1, 0, 1'b0);

    fq = '{16'h8000};
    run_frame(1'b1, 5, 1'b0);
    chk("one_count", 32'(out_count), 32'd0);

    fq = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
    run_frame(1'b0, 0, 1'b0);
    chk("c2_count", 32'(out_count2), 32'd3);
    chk("c2_ovf",   32'(out_ovf2),   32'd1);
    chk("c2_min",   32'(out_min2),   32'h0000);
    chk("c2_max",   32'(out_max2),   32'h0005);

    // reset in the middle of a frame
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    is_signed = 1'b0;
    @(posedge clk);
    #1;
    in_data = 16'h0042;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mrst_min",   32'(out_min),   32'(0));
    chk("mrst_max",   32'(out_max),   32'(0));
    chk("mrst_count", 32'(out_count), 32'(0));
    chk("mrst_ready", 32'(in_ready),  32'(1));
    chk("mrst_valid", 32'(out_valid), 32'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fq = '{16'd7, 16'd9};
    run_frame(1'b0, 0, 1'b0);
    chk("r_min",   32'(out_min),   32'd7);
    chk("r_max",   32'(out_max),   32'd9);
    chk("r_count", 32'(out_count), 32'd1);

    for (int f = 0; f < 40; f++) begin
      int len = 1 + int'($urandom % 12);
      fq = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom % 3 == 0)
          fq.push_back(16'($urandom % 4) | 16'h7FFE);
        else
          fq.push_back(16'($urandom));
      end
      run_frame(1'($urandom), int'($urandom % 3), 1'b1);
    end

    // long frame overflows the 8-bit counter
    fq = {};
    for (int i = 0; i < 300; i++)
      fq.push_back(16'($urandom));
    run_frame(1'b1, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmpminmax.md
# cmpminmax

Streaming signed/unsigned min/max tracker: consumes a frame of WIDTH-bit samples over a valid/ready stream and returns the frame minimum, maximum and their positions. It is the sequential consumer of the dual-mode less-than comparison and sits after sample producers (ADC front ends, accumulators) wherever per-frame extremes are needed. Comparisons are strict less-than, in signed or unsigned mode chosen per frame.

## Interface
- WIDTH, 16, sample width in bits
- CNTW, 8, sample index/count width in bits

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- is_signed  in  1  comparison mode (1 = two's complement), sampled with first sample of a frame
- in_valid  in  1  sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  WIDTH  sample
- in_last  in  1  sample is the last of the frame
- out_valid  out  1  frame result valid
- out_ready  in  1  result consumer ready
- out_min  out  WIDTH  frame minimum
- out_max  out  WIDTH  frame maximum
- out_min_idx  out  CNTW  index of first occurrence of minimum
- out_max_idx  out  CNTW  index of first occurrence of maximum
- out_count  out  CNTW  number of samples in frame, minus one
- out_ovf  out  1  frame exceeded 2^CNTW samples

## Operation
- States: IDLE (no sample of current frame yet), ACC (accumulating), HOLD (result presented).
- Accept = in_valid & in_ready. in_ready = 1 in IDLE and ACC, 0 in HOLD.
- IDLE, accept: min = max = in_data, both idx = 0, count = 0, mode latched from is_signed, ovf = 0; -> ACC, or -> HOLD if in_last.
- ACC, accept: count += 1; if in_data < min (latched mode) then min/min_idx update; if max < in_data then max/max_idx update; equal values never update (first occurrence wins); -> HOLD if in_last.
- Signed compare: MSBs differ -> operand with MSB=1 is smaller; otherwise unsigned compare. Unsigned: plain magnitude.
- Count saturates at 2^CNTW-1; a further accept sets out_ovf = 1 and freezes count and idx updates (min/max values still update, idx keeps last valid value).
- HOLD: out_valid = 1, outputs stable; on out_valid & out_ready -> IDLE.
- is_signed changes mid-frame are ignored.

## Timing
- Reset: state IDLE, in_ready = 1, out_valid = 0, out_min/out_max/out_*_idx/out_count = 0, out_ovf = 0.
- Latency: out_valid rises the cycle after the in_last accept.
- One-sample frame (in_last on first accept): HOLD next cycle, min = max = that sample, count = 0.
- Result handshake cycle: in_ready stays 0; in_ready returns to 1 the cycle after out_ready handshake (one-cycle bubble between frames).
- out_ready asserted while out_valid = 0: no effect.
- Reset mid-frame or during HOLD: immediate return to reset values; partial frame discarded.
- Registered outputs only; no combinational path from in_* to out_*. in_ready depends only on state.

## Configuration
- CMPMINMAX_IDX_EN defined: index registers, out_min_idx/out_max_idx tracking as above.
- Not defined: index registers removed, out_min_idx and out_max_idx tied to 0; min/max/count/ovf unchanged.

## Test plan
- Unsigned frame 0x0002, 0xFFFF, 0x0001 (is_signed=0, in_last on third) -> min 0x0001 idx 2, max 0xFFFF idx 1, count 2, out_valid one cycle after last.
- Same samples with is_signed=1 -> min 0xFFFF idx 1, max 0x0002 idx 0.
- Signed frame 0xFFFE, 0xFFFF, 0xFFFE, 0xFFFF -> min 0xFFFE idx 0, max 0xFFFF idx 1 (ties keep first).
- Single sample 0x8000 with in_last, out_ready held 0 for 5 cycles -> min = max = 0x8000, count 0, outputs stable, in_ready 0 throughout, in_ready 1 one cycle after out_ready pulse.
- CNTW=2, 6-sample frame 5,4,3,2,1,0 unsigned -> count 3, out_ovf 1, min 0x0000, max 0x0005 idx 0.
- Assert rst_n=0 after 2 samples of a frame -> all outputs reset values, next frame 7,9 -> min 7, max 9, count 1.
